// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU, branch, load and store codes plus the
// decoder control bundle carried down the pipeline.
package mips_pkg;

  typedef enum logic [3:0] {
    A_NOP  = 4'd0,
    A_ADD  = 4'd1,
    A_SUB  = 4'd2,
    A_AND  = 4'd3,
    A_OR   = 4'd4,
    A_XOR  = 4'd5,
    A_NOR  = 4'd6,
    A_SLT  = 4'd7,
    A_SLTU = 4'd8,
    A_SLL  = 4'd9,
    A_SRL  = 4'd10,
    A_SRA  = 4'd11,
    A_LUI  = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    BRANCH_BEQ  = 3'd0,
    BRANCH_BNE  = 3'd1,
    BRANCH_BLEZ = 3'd2,
    BRANCH_BGTZ = 3'd3,
    BRANCH_BLTZ = 3'd4,
    BRANCH_BGEZ = 3'd5
  } branch_type_e;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    STORE_SW = 2'd0,
    STORE_SB = 2'd1,
    STORE_SH = 2'd2
  } store_type_e;

  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic [3:0] alu_control;
    logic       mem_write;
    logic       alu_src;
    logic       alu_shift_shamt;
    logic       reg_write;
    logic       jump;
    logic       jump_reg;
    logic       reg_dst;
    logic [2:0] branch_type;
    logic [2:0] load_type;
    logic [1:0] store_type;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // rt is a source operand unless the instruction takes an immediate and
  // neither stores rt nor compares it in a branch.
  function automatic logic rt_consumed(input logic alu_src, input logic mem_write,
                                       input logic branch);
    return ~alu_src | mem_write | branch;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline boundary signals. id_valid qualifies id_*, stall is
// the back-pressure to IF/ID (decode may advance when stall=0), ex_valid qualifies ex_*.
interface id_ex_reg_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc4;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [4:0]        id_shamt;
  logic              flush;

  logic              ex_valid;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc4;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_shamt;
  logic [4:0]        ex_dest;
  logic              stall;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc4,
           id_rs, id_rt, id_rd, id_shamt, flush,
    input  ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_shamt, ex_dest, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc4,
           id_rs, id_rt, id_rd, id_shamt, flush,
    output ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_shamt, ex_dest, stall, stall_cnt
  );

endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard comparator: a load in execute whose destination feeds the
// instruction currently in decode.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_dest,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic       id_branch,
  output logic       hazard
);

  logic load_in_ex;
  logic rs_match;
  logic rt_match;

  // $zero is never a real producer, so a load targeting it cannot stall.
  assign load_in_ex = ex_valid & ex_mem_to_reg & (ex_dest != 5'd0);
  assign rs_match   = (ex_dest == id_rs);
  assign rt_match   = (ex_dest == id_rt) & rt_consumed(id_alu_src, id_mem_write, id_branch);
  assign hazard     = load_in_ex & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion on flush, invalid decode and
// (when HAZARD_DETECT_EN is defined) load-use stalls with a saturating stall counter.
module id_ex_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
)(
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);

  logic              ex_valid_q;
  ctrl_t             ex_ctrl_q;
  logic [DATA_W-1:0] ex_rs_data_q;
  logic [DATA_W-1:0] ex_rt_data_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [DATA_W-1:0] ex_pc4_q;
  logic [4:0]        ex_rs_q;
  logic [4:0]        ex_rt_q;
  logic [4:0]        ex_shamt_q;
  logic [4:0]        ex_dest_q;
  logic              stall;
  logic              load_bubble;

`ifdef HAZARD_DETECT_EN
  logic        hazard;
  logic [15:0] stall_cnt_q;

  hazard_detect u_hazard_detect (
    .ex_valid      (ex_valid_q),
    .ex_mem_to_reg (ex_ctrl_q.mem_to_reg),
    .ex_dest       (ex_dest_q),
    .id_valid      (bus.id_valid),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .id_alu_src    (bus.id_ctrl.alu_src),
    .id_mem_write  (bus.id_ctrl.mem_write),
    .id_branch     (bus.id_ctrl.branch),
    .hazard        (hazard)
  );

  // Flush kills the decode instruction, so holding it would be pointless.
  assign stall = hazard & ~bus.flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign stall         = 1'b0;
  assign bus.stall_cnt = 16'd0;
`endif

  assign bus.stall   = stall;
  assign load_bubble = bus.flush | stall | ~bus.id_valid;

  // A bubble zeroes every field, data included, so execute sees a fixed pattern.
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_pc4_q     <= '0;
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_shamt_q   <= 5'd0;
      ex_dest_q    <= 5'd0;
    end else begin
      ex_valid_q   <= bus.id_valid;
      ex_ctrl_q    <= bus.id_ctrl;
      ex_rs_data_q <= bus.id_rs_data;
      ex_rt_data_q <= bus.id_rt_data;
      ex_imm_q     <= bus.id_imm;
      ex_pc4_q     <= bus.id_pc4;
      ex_rs_q      <= bus.id_rs;
      ex_rt_q      <= bus.id_rt;
      ex_shamt_q   <= bus.id_shamt;
      ex_dest_q    <= bus.id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_rs_data = ex_rs_data_q;
  assign bus.ex_rt_data = ex_rt_data_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_pc4     = ex_pc4_q;
  assign bus.ex_rs      = ex_rs_q;
  assign bus.ex_rt      = ex_rt_q;
  assign bus.ex_shamt   = ex_shamt_q;
  assign bus.ex_dest    = ex_dest_q;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, 32, datapath width of operand, immediate and PC fields.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_ctrl  in  ctrl bundle  decoder outputs: branch, mem_to_reg, alu_control[3:0], mem_write, alu_src, alu_shift_shamt, reg_write, jump, jump_reg, reg_dst, branch_type[2:0], load_type[2:0], store_type[1:0].
REQ-006 id_rs_data, id_rt_data, id_imm, id_pc4  in  DATA_W each  register operands, sign/zero-extended immediate, PC+4.
REQ-007 id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction register and shift fields.
REQ-008 flush  in  1  taken branch/jump resolved downstream; kill instruction in decode.
REQ-009 ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_shamt  out  registered copies for execute stage.
REQ-010 ex_dest  out  5  registered write-back register: id_rd if reg_dst else id_rt.
REQ-011 stall  out  1  combinational; hold PC and IF/ID register this cycle.
REQ-012 stall_cnt  out  16  bubbles inserted due to load-use, saturating.

Function
REQ-013 Latency exactly one cycle: inputs sampled at edge N appear on ex_* after edge N.
REQ-014 Load-use hazard SHALL be: ex_valid & ex_ctrl.mem_to_reg & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & rt consumed)) & id_valid; rt consumed when alu_src=0 or mem_write=1 or branch=1.
REQ-015 On hazard with flush=0: stall=1, register loads bubble (ex_valid=0, all ex_ctrl fields 0), stall_cnt increments by 1 unless at 16'hFFFF.
REQ-016 Stall lasts exactly one cycle per load; next cycle the load has left execute, hazard clears, held instruction captured normally.
REQ-017 flush=1 SHALL load bubble and force stall=0 regardless of hazard; flush has priority over stall and over capture.
REQ-018 id_valid=0 with no flush/hazard SHALL load bubble; stall=0.
REQ-019 Bubble SHALL zero ex_ctrl so reg_write, mem_write, branch, jump, jump_reg are 0; data fields may hold don't-care values but SHALL be zeroed for determinism.
REQ-020 Register 0 as ex_dest never raises hazard.
REQ-021 Normal capture: all ex_* take id_* values, ex_valid=id_valid.

Reset
REQ-022 rst=1 at an edge SHALL clear ex_valid, all ex_ctrl, data, index fields, ex_dest and stall_cnt to 0, overriding flush and hazard.
REQ-023 During rst, stall SHALL read 0 (hazard gated by ex_valid, which is 0).
REQ-024 Reset mid-stall discards held state; first post-reset capture behaves as normal.

Configuration
REQ-025 Macro HAZARD_DETECT_EN defined: REQ-014..REQ-016 and stall_cnt active.
REQ-026 HAZARD_DETECT_EN undefined: stall tied 0, stall_cnt tied 0, no hazard logic; external unit owns load-use stalling; all other behaviour unchanged.

Structure
REQ-027 Shared package mips_pkg SHALL hold ALU codes A_NOP..A_LUI (0..12), BRANCH_*, LOAD_*, STORE_* codes, and the ctrl bundle typedef shared with the decoder.
REQ-028 Sub-module hazard_detect SHALL contain REQ-014 comparison logic, instantiated only under HAZARD_DETECT_EN.

Verification
REQ-029 lw $t0 in ex (ex_dest=8), add $t1,$t0,$t2 in id -> stall=1 one cycle, bubble on ex, stall_cnt 0->1, add captured next cycle.
REQ-030 lw ex_dest=8, id addi rt=8 (alu_src=1, rs=9) -> stall=0, addi captured.
REQ-031 Hazard and flush=1 same cycle -> stall=0, ex_valid=0, stall_cnt unchanged.
REQ-032 lw ex_dest=0, id rs=0 -> stall=0.
REQ-033 Assert rst during stall cycle -> next cycle all ex_* 0, stall_cnt=0, stall=0.
REQ-034 Force stall_cnt=16'hFFFF, trigger hazard -> stall_cnt stays 16'hFFFF, bubble still inserted.
